// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - opcodes, flag indices, CRC and error-packet helpers for the ALU core
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Bit positions inside the 4-bit {Carry, Overflow, Zero, Negative} flag vector
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Widest message either CRC helper accepts; callers zero-extend and pass the real length
  localparam int CRC_MAX_W = 256;

  function automatic logic [3:0] next_crc4(input logic [CRC_MAX_W-1:0] d, input int n);
    logic [3:0] crc;
    logic       fb;
    crc = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb  = d[8'(i)] ^ crc[3];
      crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return crc;
  endfunction

  function automatic logic [2:0] next_crc3(input logic [CRC_MAX_W-1:0] d, input int n);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb  = d[8'(i)] ^ crc[2];
      crc = {crc[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return crc;
  endfunction

  // Bit 0 makes the whole packet even parity
  function automatic logic [7:0] err_packet(input logic err_crc, input logic err_op);
    logic [6:0] head;
    head = {1'b1, 1'b0, err_crc, err_op, 1'b0, err_crc, err_op};
    return {head, ^head};
  endfunction

endpackage

// File: rtl/mtm_alu_exec.sv
// rtl/mtm_alu_exec.sv - stage-2 combinational result, flag and CTL word computation
module mtm_alu_exec
  import mtm_alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 3,
  parameter int CRC_OUT_W = 3
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  input  logic              err_crc,
  input  logic              err_op,
  output logic [DATA_W-1:0] c,
  output logic [7:0]        ctl,
  output logic              err
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]    sum;
  logic [DATA_W:0]    diff;
  logic [DATA_W-1:0]  res;
  logic               carry;
  logic               ovf;
  logic [3:0]         flags;
  logic [CRC_OUT_W-1:0] crc3;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_W'(OP_AND): res = a & b;
      OP_W'(OP_OR):  res = a | b;
      OP_W'(OP_ADD): begin
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
        ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_W'(OP_SUB): begin
        // The extra top bit of the widened difference is the borrow
        res   = diff[DATA_W-1:0];
        carry = diff[DATA_W];
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      default: ;
    endcase

    flags         = '0;
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_N] = res[MSB];

    crc3 = CRC_OUT_W'(next_crc3(CRC_MAX_W'({res, 1'b0, flags}), DATA_W + 5));

    if (err_crc || err_op) begin
      c   = '0;
      ctl = err_packet(err_crc, err_op);
      err = 1'b1;
    end else begin
      c   = res;
      ctl = {1'b0, flags, crc3};
      err = 1'b0;
    end
  end

endmodule

// File: rtl/mtm_alu_core_pipe.sv
// rtl/mtm_alu_core_pipe.sv - two-stage backpressurable ALU core; MTM_ALU_CRC_CHECK_EN enables input CRC4 check
module mtm_alu_core_pipe
  import mtm_alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 3,
  parameter int CRC_IN_W  = 4,
  parameter int CRC_OUT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [OP_W-1:0]     op,
  input  logic [CRC_IN_W-1:0] crc_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   c,
  output logic [7:0]          ctl_out,
  output logic                out_err
);

  logic              s1_valid;
  logic              s2_valid;
  logic              adv1;
  logic              adv2;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [OP_W-1:0]   s1_op;
  logic              s1_err_crc;
  logic              s1_err_op;
  logic              in_err_crc;
  logic              in_err_op;
  logic [DATA_W-1:0] x_c;
  logic [7:0]        x_ctl;
  logic              x_err;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

`ifdef MTM_ALU_CRC_CHECK_EN
  localparam int CRC4_MSG_W = 2 * DATA_W + 1 + OP_W;
  logic [CRC4_MSG_W-1:0] crc4_msg;
  assign crc4_msg   = {b, a, 1'b1, op};
  assign in_err_crc = (crc_in != CRC_IN_W'(next_crc4(CRC_MAX_W'(crc4_msg), CRC4_MSG_W)));
`else
  logic unused_crc_in;
  assign unused_crc_in = ^crc_in;
  assign in_err_crc    = 1'b0;
`endif

  // A corrupted packet cannot be trusted to carry a meaningful opcode
  assign in_err_op = !in_err_crc &&
                     !((op == OP_W'(OP_AND)) || (op == OP_W'(OP_OR)) ||
                       (op == OP_W'(OP_ADD)) || (op == OP_W'(OP_SUB)));

  mtm_alu_exec #(
    .DATA_W   (DATA_W),
    .OP_W     (OP_W),
    .CRC_OUT_W(CRC_OUT_W)
  ) u_exec (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .err_crc(s1_err_crc),
    .err_op (s1_err_op),
    .c      (x_c),
    .ctl    (x_ctl),
    .err    (x_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      c        <= '0;
      ctl_out  <= '0;
      out_err  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a       <= a;
          s1_b       <= b;
          s1_op      <= op;
          s1_err_crc <= in_err_crc;
          s1_err_op  <= in_err_op;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          c       <= x_c;
          ctl_out <= x_ctl;
          out_err <= x_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_core_pipe.sv
// tb/tb_mtm_alu_core_pipe.sv - directed table-driven bench for mtm_alu_core_pipe
module tb_mtm_alu_core_pipe;

  localparam int DW = 32;

`ifdef MTM_ALU_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [2:0]    op;
  logic [3:0]    crc_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] c;
  logic [7:0]    ctl_out;
  logic          out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mtm_alu_core_pipe #(.DATA_W(DW), .OP_W(3), .CRC_IN_W(4), .CRC_OUT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .crc_in   (crc_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .ctl_out  (ctl_out),
    .out_err  (out_err)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        bad_crc;
    logic        exp_err;
    logic [31:0] exp_c;
    logic [3:0]  exp_flags;
    logic [7:0]  exp_ctl_err;
  } vec_t;

  vec_t vecs [12];

  // CRCs as polynomial remainders of msg * x^k
  function automatic logic [3:0] m_crc4(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [2:0] mop);
    logic [71:0] r;
    r = {mb, ma, 1'b1, mop, 4'b0000};
    for (int k = 0; k < 68; k++) begin
      if (r[71]) r[71:67] = r[71:67] ^ 5'b10011;
      r = r << 1;
    end
    return r[71:68];
  endfunction

  function automatic logic [2:0] m_crc3(input logic [31:0] mc, input logic [3:0] mf);
    logic [39:0] r;
    r = {mc, 1'b0, mf, 3'b000};
    for (int k = 0; k < 37; k++) begin
      if (r[39]) r[39:36] = r[39:36] ^ 4'b1011;
      r = r << 1;
    end
    return r[39:37];
  endfunction

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] vop,
                              input logic bad, input logic e, input logic [31:0] ec,
                              input logic [3:0] ef, input logic [7:0] ectl);
    vec_t v;
    v.a = va; v.b = vb; v.op = vop; v.bad_crc = bad;
    v.exp_err = e; v.exp_c = ec; v.exp_flags = ef; v.exp_ctl_err = ectl;
    return v;
  endfunction

  function automatic logic [7:0] exp_ctl(input vec_t v);
    if (v.exp_err) return v.exp_ctl_err;
    return {1'b0, v.exp_flags, m_crc3(v.exp_c, v.exp_flags)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a        = v.a;
    b        = v.b;
    op       = v.op;
    crc_in   = m_crc4(v.a, v.b, v.op) ^ {3'b000, v.bad_crc};
    in_valid = 1'b1;
  endtask

  task automatic check_out(input string nm, input vec_t v);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'(1));
    chk({nm, "_c"}, 64'(c), 64'(v.exp_c));
    chk({nm, "_ctl"}, 64'(ctl_out), 64'(exp_ctl(v)));
    chk({nm, "_err"}, 64'(out_err), 64'(v.exp_err));
  endtask

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("v%0d", i);
    @(negedge clk);
    drive(vecs[i]);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_lat1_out_valid"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    check_out(nm, vecs[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t p0, p1, p2;

    vecs[0]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 4'b1010, 8'h00);
    vecs[1]  = mk(32'h8000_0000, 32'h0000_0001, 3'b101, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b0100, 8'h00);
    vecs[2]  = mk(32'h0000_0001, 32'h0000_0002, 3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1001, 8'h00);
    vecs[3]  = mk(32'h0000_00F0, 32'h0000_003C, 3'b000, 1'b0, 1'b0, 32'h0000_0030, 4'b0000, 8'h00);
    vecs[4]  = mk(32'h0000_00F0, 32'h0000_003C, 3'b001, 1'b0, 1'b0, 32'h0000_00FC, 4'b0000, 8'h00);
    vecs[5]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 1'b0, 1'b0, 32'h8000_0000, 4'b0101, 8'h00);
    vecs[6]  = mk(32'h0000_0005, 32'h0000_0005, 3'b101, 1'b0, 1'b0, 32'h0000_0000, 4'b0010, 8'h00);
    vecs[7]  = mk(32'h1234_5678, 32'h9ABC_DEF0, 3'b010, 1'b0, 1'b1, 32'h0, 4'b0000, 8'b1001_0011);
    vecs[8]  = mk(32'h0000_0001, 32'h0000_0001, 3'b111, 1'b0, 1'b1, 32'h0, 4'b0000, 8'b1001_0011);
    vecs[9]  = CRC_EN ? mk(32'h5, 32'h3, 3'b100, 1'b1, 1'b1, 32'h0, 4'b0000, 8'b1010_0101)
                      : mk(32'h5, 32'h3, 3'b100, 1'b1, 1'b0, 32'h8, 4'b0000, 8'h00);
    vecs[10] = CRC_EN ? mk(32'hF0, 32'h3C, 3'b000, 1'b1, 1'b1, 32'h0, 4'b0000, 8'b1010_0101)
                      : mk(32'hF0, 32'h3C, 3'b000, 1'b1, 1'b0, 32'h30, 4'b0000, 8'h00);
    vecs[11] = CRC_EN ? mk(32'h7, 32'h9, 3'b011, 1'b1, 1'b1, 32'h0, 4'b0000, 8'b1010_0101)
                      : mk(32'h7, 32'h9, 3'b011, 1'b1, 1'b1, 32'h0, 4'b0000, 8'b1001_0011);

    p0 = mk(32'h1, 32'h2, 3'b100, 1'b0, 1'b0, 32'h3, 4'b0000, 8'h00);
    p1 = mk(32'h0, 32'h1, 3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1001, 8'h00);
    p2 = mk(32'hFF00_FF00, 32'h0FF0_0FF0, 3'b000, 1'b0, 1'b0, 32'h0F00_0F00, 4'b0000, 8'h00);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; crc_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_c", 64'(c), 64'(0));
    chk("rst_ctl", 64'(ctl_out), 64'(0));
    chk("rst_err", 64'(out_err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 12; i++) run_vec(i);

    // Backpressure: two ops fill the pipe, the third must wait
    @(negedge clk);
    out_ready = 1'b0;
    drive(p0);
    chk("bp_in_ready0", 64'(in_ready), 64'(1));
    @(negedge clk);
    drive(p1);
    chk("bp_in_ready1", 64'(in_ready), 64'(1));
    @(negedge clk);
    drive(p2);
    chk("bp_in_ready_drop", 64'(in_ready), 64'(0));
    check_out("bp_p0", p0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'(0));
      check_out($sformatf("bp_hold%0d", k), p0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp_p1", p1);
    @(negedge clk);
    check_out("bp_p2", p2);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'(0));

    // Reset with both stages occupied
    @(negedge clk);
    out_ready = 1'b0;
    drive(p0);
    @(negedge clk);
    drive(p1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    chk("mrst_ctl", 64'(ctl_out), 64'(0));
    chk("mrst_c", 64'(c), 64'(0));
    chk("mrst_err", 64'(out_err), 64'(0));
    chk("mrst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    run_vec(0);
    @(negedge clk);
    chk("final_out_valid", 64'(out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
